// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one SIZE-bit right shifter/rotator between two requesters.
// Defining SHIFTER_ARB_STATS_EN adds saturating per-requester grant counters and stats_clr.
module shifter_arbiter #(
    parameter int SIZE = 4,
    localparam int AMT_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SIZE-1:0]  req0_a,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_rot,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SIZE-1:0]  req1_a,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_rot,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SIZE-1:0]  res_y,
    output logic             res_id
`ifdef SHIFTER_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [7:0]       gnt0_cnt,
    output logic [7:0]       gnt1_cnt
`endif
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t state, state_d;
    logic last_grant, can_accept, gnt1, accept;
    logic [SIZE-1:0] sel_a;
    logic [AMT_W-1:0] sel_amt;
    logic sel_rot;

    // Rotation reuses the shifter by feeding a copy of the operand into the upper half.
    function automatic logic [SIZE-1:0] shift(input logic [SIZE-1:0] a, input logic [AMT_W-1:0] amt, input logic rot);
        logic [2*SIZE-1:0] w;
        w = {rot ? a : {SIZE{1'b0}}, a} >> amt;
        return w[SIZE-1:0];
    endfunction

    always_comb begin
        can_accept = !rst && (state == IDLE || res_ready);
        gnt1 = req1_valid && (!req0_valid || !last_grant);
        req0_ready = can_accept && req0_valid && !gnt1;
        req1_ready = can_accept && gnt1;
        accept = req0_ready || req1_ready;
        state_d = accept ? FULL : (res_ready ? IDLE : state);
        sel_a = gnt1 ? req1_a : req0_a;
        sel_amt = gnt1 ? req1_amt : req0_amt;
        sel_rot = gnt1 ? req1_rot : req0_rot;
    end

    assign res_valid = state == FULL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res_y <= '0;
            res_id <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_d;
            if (accept) begin
                res_y <= shift(sel_a, sel_amt, sel_rot);
                res_id <= req1_ready;
                last_grant <= req1_ready;
            end
        end
    end

`ifdef SHIFTER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (req0_ready && gnt0_cnt != 8'hff) gnt0_cnt <= gnt0_cnt + 8'd1;
            if (req1_ready && gnt1_cnt != 8'hff) gnt1_cnt <= gnt1_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: directed stimulus, per-cycle behavioural model compare plus literal checks.
module tb_shifter_arbiter;
    localparam int SIZE = 4;
    localparam int AMT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v0 = 0, v1 = 0, rot0 = 0, rot1 = 0, rr = 0;
    logic [SIZE-1:0] a0 = '0, a1 = '0;
    logic [AMT_W-1:0] amt0 = '0, amt1 = '0;
    logic r0, r1, res_valid, res_id;
    logic [SIZE-1:0] res_y;
    logic stats_clr = 1'b0;
    logic [7:0] gnt0_cnt, gnt1_cnt;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    shifter_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_amt(amt0), .req0_rot(rot0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_amt(amt1), .req1_rot(rot1),
        .res_valid(res_valid), .res_ready(rr), .res_y(res_y), .res_id(res_id)
`ifdef SHIFTER_ARB_STATS_EN
        , .stats_clr(stats_clr), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

`ifndef SHIFTER_ARB_STATS_EN
    assign gnt0_cnt = '0;
    assign gnt1_cnt = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Bit-by-bit reference of the shift rule.
    function automatic logic [SIZE-1:0] mshift(input logic [SIZE-1:0] a, input int amt, input logic rot);
        logic [SIZE-1:0] y;
        for (int i = 0; i < SIZE; i++)
            y[i] = (i + amt < SIZE) ? a[i + amt] : (rot ? a[i + amt - SIZE] : 1'b0);
        return y;
    endfunction

    logic m_full = 0, m_id = 0, m_last = 1;
    logic [SIZE-1:0] m_y = '0;
    int m_c0 = 0, m_c1 = 0;

    // Compare on the falling edge, then advance the model to what the next rising edge must produce.
    always @(negedge clk) begin
        bit open, e0, e1;
        int win;
        check("res_valid", res_valid, m_full);
        check("res_y", res_y, m_y);
        check("res_id", res_id, m_id);
        open = !rst && (!m_full || rr);
        win = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
        e0 = open && (v0 || v1) && win == 0;
        e1 = open && (v0 || v1) && win == 1;
        check("req0_ready", r0, e0);
        check("req1_ready", r1, e1);
`ifdef SHIFTER_ARB_STATS_EN
        check("gnt0_cnt", gnt0_cnt, m_c0);
        check("gnt1_cnt", gnt1_cnt, m_c1);
`endif
        if (rst) begin
            m_full = 0; m_y = '0; m_id = 0; m_last = 1; m_c0 = 0; m_c1 = 0;
        end else begin
            if (e0 || e1) begin
                m_y = e1 ? mshift(a1, amt1, rot1) : mshift(a0, amt0, rot0);
                m_id = e1;
                m_last = e1;
                m_full = 1;
            end else if (rr) m_full = 0;
            if (stats_clr) begin
                m_c0 = 0; m_c1 = 0;
            end else begin
                if (e0) m_c0 = (m_c0 == 255) ? 255 : m_c0 + 1;
                if (e1) m_c1 = (m_c1 == 255) ? 255 : m_c1 + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        logic [SIZE-1:0] held_y;
        tick(); tick();
        check("reset res_valid", res_valid, 1'b0);
        check("reset res_y", res_y, 4'b0000);
        check("reset res_id", res_id, 1'b0);
        rst = 0; rr = 1;
        v0 = 1; a0 = 4'b1011; amt0 = 1; rot0 = 0;
        #1 check("t1 req0_ready", r0, 1'b1);
        tick(); v0 = 0;
        check("t1 res_valid", res_valid, 1'b1);
        check("t1 res_y", res_y, 4'b0101);
        check("t1 res_id", res_id, 1'b0);
        v1 = 1; a1 = 4'b1011; amt1 = 2; rot1 = 1;
        tick();
        check("rot res_y", res_y, 4'b1110);
        check("rot res_id", res_id, 1'b1);
        rot1 = 0;
        tick(); v1 = 0;
        check("shift2 res_y", res_y, 4'b0010);
        rst = 1; tick(); rst = 0;
        // Contention: only the accepted requester advances its payload.
        v0 = 1; v1 = 1; a0 = 4'd1; a1 = 4'd8; amt0 = 0; amt1 = 0; rot0 = 0; rot1 = 0;
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2 == 0);
            #1 check("rr req0_ready", r0, exp0);
            check("rr req1_ready", r1, !exp0);
            tick();
            check("rr res_id", res_id, !exp0);
            check("rr res_y", res_y, exp0 ? a0 : a1);
            if (exp0) a0 = a0 + 4'd1; else a1 = a1 + 4'd1;
        end
        rr = 0; held_y = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp req0_ready", r0, 1'b0);
            check("bp req1_ready", r1, 1'b0);
            tick();
            check("bp res_id", res_id, 1'b1);
            check("bp res_y", res_y, held_y);
        end
        rr = 1;
        #1 check("resume req0_ready", r0, 1'b1);
        tick();
        check("resume res_id", res_id, 1'b0);
        check("resume res_y", res_y, 4'd3);
        v0 = 0; v1 = 0; tick();
        v0 = 1; a0 = 4'b0110; amt0 = 1; tick(); v0 = 0;
        check("mid res_valid", res_valid, 1'b1);
        rst = 1; v0 = 1; v1 = 1;
        #1 check("rst req0_ready", r0, 1'b0);
        check("rst req1_ready", r1, 1'b0);
        tick(); rst = 0;
        check("mid-rst res_valid", res_valid, 1'b0);
        check("mid-rst res_y", res_y, 4'b0000);
        #1 check("post-rst req0_ready", r0, 1'b1);
        tick(); v0 = 0; v1 = 0; tick();
`ifdef SHIFTER_ARB_STATS_EN
        rst = 1; tick(); rst = 0;
        v0 = 1;
        repeat (300) tick();
        v0 = 0;
        check("gnt0 sat", gnt0_cnt, 8'd255);
        check("gnt1 zero", gnt1_cnt, 8'd0);
        v1 = 1; stats_clr = 1;
        tick(); v1 = 0; stats_clr = 0;
        check("clr gnt0", gnt0_cnt, 8'd0);
        check("clr gnt1", gnt1_cnt, 8'd0);
        tick();
`endif
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
